mult8x8_seq_ctrl: RTL and testbench
===================================

Name: mult8x8_seq_ctrl

Overview:
Sequencing controller and accumulator for the sequential 8x8 multiplier.
- Reuses one 4x4 nibble multiply and the 0/4/8 nibble-shift stage.
- Steps through the four nibble partial products over four clock cycles and accumulates them into a 16-bit product.
- Signals completion with a held done flag.
- Sits between the operand source (switches or host) and the product display or consumer.

Parameters:
START_EDGE, 1, 1 = start is rising-edge detected (one run per press); 0 = start is level-sensitive (runs back-to-back while held).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request a new multiplication
dataa  input  8  multiplicand, sampled at the accepting edge
datab  input  8  multiplier, sampled at the accepting edge
product  output  16  accumulated product; final value valid while done_flag=1
done_flag  output  1  high from completion until the next accepted start or reset
busy  output  1  high while in CALC

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, count=0, operand regs=0.
  - product=0, done_flag=0, busy=0.
  - Reset overrides every other input, including mid-CALC; a partial result is discarded.
- States: IDLE, CALC, DONE.
- Accept condition:
  - START_EDGE=1: start=1 and start_q=0, where start_q is start registered each cycle and reset to 0.
  - START_EDGE=0: start=1.
- IDLE or DONE, accept at edge E0:
  - latch dataa/datab, product<=0, count<=0, done_flag<=0, state<=CALC, busy<=1.
- CALC, one partial product per edge, count 0..3:
  - count 0: a[3:0]*b[3:0], shift_cntr=00 (<<0)
  - count 1: a[3:0]*b[7:4], shift_cntr=01 (<<4)
  - count 2: a[7:4]*b[3:0], shift_cntr=01 (<<4)
  - count 3: a[7:4]*b[7:4], shift_cntr=10 (<<8)
  - Each edge: product <= product + shifted partial product; count++.
  - Nibble product is 8 bits, zero-extended to 16 before the shift. Addition is 16-bit unsigned; the 8x8 result never exceeds 0xFE01, so there is no overflow.
  - shift_cntr=11 is never generated.
- At edge E4 (the count=3 accumulate): state<=DONE, busy<=0, done_flag<=1, count wraps to 0.
- Latency: done_flag and final product are visible 4 cycles after the accepting edge E0.
- start during CALC is ignored; operands are not re-sampled and no queueing occurs.
  - With START_EDGE=1, start_q still tracks start during CALC, so a press held through completion does not retrigger.
- DONE: product and done_flag are held until an accept, which behaves as in IDLE and clears done_flag at that same edge. No IDLE return is required.
- dataa/datab changing outside the accepting edge has no effect.

Optional Feature:
MULT_CTRL_DBG_EN
- Defined: adds output ports dbg_state[1:0] (IDLE=00, CALC=01, DONE=10), dbg_count[1:0], and dbg_shift_cntr[1:0].
  - dbg_shift_cntr is the shift code applied in the current CALC cycle; 00 outside CALC.
  - All debug outputs are 0 in reset.
- Undefined: these ports and their logic are absent. Functional behaviour is identical either way.

Test Plan:
- Reset then idle, start=0 for 10 cycles -> product=0x0000, done_flag=0, busy=0 throughout.
- dataa=0x12, datab=0x34, 1-cycle start -> busy=1 for 4 cycles; product after each CALC edge = 8, 104, 168, 936 (0x03A8); done_flag=1 on cycle 5 and held.
- dataa=0xFF, datab=0xFF -> product=0xFE01 with done_flag=1. Then dataa=7, datab=9 with a new start -> done_flag=0 at the accepting edge; final product=0x003F.
- Start pulsed again during CALC of 0x12*0x34, with dataa/datab changed to 0xFF -> ignored; result 0x03A8 at the original timing.
- rst_n=0 for one edge at CALC count=2 -> next cycle product=0, busy=0, done_flag=0, state IDLE. A subsequent start computes correctly.
- START_EDGE=1 with start held high for 12 cycles -> exactly one run. With START_EDGE=0 -> back-to-back runs:
  - DONE lasts 1 cycle, then a restart.
  - done_flag pulses every 5 cycles.

Source files
------------

// File: rtl/mult8x8_seq_ctrl.sv
// mult8x8_seq_ctrl: sequencing controller and accumulator for a sequential 8x8 multiplier.
// One 4x4 nibble multiply and a 0/4/8 shift stage are reused over four cycles. The four
// partial products are accumulated into a 16-bit product. A held done flag marks completion.
//
// Parameters:
//   START_EDGE - 1: start is rising-edge detected (one run per press)
//                0: start is level-sensitive (back-to-back runs while held)
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   start     - request a new multiplication
//   dataa     - multiplicand, sampled at the accepting edge
//   datab     - multiplier, sampled at the accepting edge
//   product   - accumulated product, final while done_flag=1
//   done_flag - high from completion until the next accepted start or reset
//   busy      - high while calculating
//
// Optional build macro MULT_CTRL_DBG_EN adds debug outputs:
//   dbg_state[1:0]      - IDLE=00, CALC=01, DONE=10
//   dbg_count[1:0]      - partial-product step counter
//   dbg_shift_cntr[1:0] - shift code applied this CALC cycle, 00 outside CALC

module mult8x8_seq_ctrl #(
    parameter bit START_EDGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product,
    output logic        done_flag,
    output logic        busy
`ifdef MULT_CTRL_DBG_EN
    ,
    output logic [1:0]  dbg_state,
    output logic [1:0]  dbg_count,
    output logic [1:0]  dbg_shift_cntr
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] product_q, product_d;
    logic        done_q, done_d;
    logic        start_q;

    logic        accept;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  nib_prod;
    logic [1:0]  shift_cntr;
    logic [15:0] pp_shifted;

    // start_q follows start in every state, so a press held through completion
    // cannot retrigger in edge mode.
    assign accept = start & (START_EDGE ? ~start_q : 1'b1);

    // Step order: lo*lo, lo*hi, hi*lo, hi*hi. count[1] picks the a nibble,
    // count[0] picks the b nibble.
    assign a_nib    = count_q[1] ? a_q[7:4] : a_q[3:0];
    assign b_nib    = count_q[0] ? b_q[7:4] : b_q[3:0];
    assign nib_prod = {4'b0000, a_nib} * {4'b0000, b_nib};

    always_comb begin
        shift_cntr = 2'b00;
        unique case (count_q)
            2'd0:    shift_cntr = 2'b00;
            2'd1:    shift_cntr = 2'b01;
            2'd2:    shift_cntr = 2'b01;
            default: shift_cntr = 2'b10;
        endcase
    end

    always_comb begin
        pp_shifted = 16'h0000;
        unique case (shift_cntr)
            2'b00:   pp_shifted = {8'h00, nib_prod};
            2'b01:   pp_shifted = {4'h0, nib_prod, 4'h0};
            2'b10:   pp_shifted = {nib_prod, 8'h00};
            default: pp_shifted = 16'h0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        done_d    = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    a_d       = dataa;
                    b_d       = datab;
                    product_d = 16'h0000;
                    count_d   = 2'd0;
                    done_d    = 1'b0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                // No overflow: the largest 8x8 result is 0xFE01.
                product_d = product_q + pp_shifted;
                count_d   = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= 2'd0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            product_q <= 16'h0000;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            done_q    <= done_d;
            start_q   <= start;
        end
    end

    assign product   = product_q;
    assign done_flag = done_q;
    assign busy      = (state_q == StCalc);

`ifdef MULT_CTRL_DBG_EN
    assign dbg_state      = state_q;
    assign dbg_count      = count_q;
    assign dbg_shift_cntr = (state_q == StCalc) ? shift_cntr : 2'b00;
`endif

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl. Two instances share stimulus: one edge-triggered
// start, one level-sensitive start. An arithmetic model predicts both every cycle; directed
// literal checks pin the model to hand-computed values.

module tb_mult8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;

    logic [15:0] prod_e, prod_l;
    logic        done_e, done_l;
    logic        busy_e, busy_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef MULT_CTRL_DBG_EN
    logic [1:0] dst_e, dcnt_e, dsh_e, dst_l, dcnt_l, dsh_l;
`endif

    mult8x8_seq_ctrl #(.START_EDGE(1'b1)) dut_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .product   (prod_e),
        .done_flag (done_e),
        .busy      (busy_e)
`ifdef MULT_CTRL_DBG_EN
        ,
        .dbg_state      (dst_e),
        .dbg_count      (dcnt_e),
        .dbg_shift_cntr (dsh_e)
`endif
    );

    mult8x8_seq_ctrl #(.START_EDGE(1'b0)) dut_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .product   (prod_l),
        .done_flag (done_l),
        .busy      (busy_l)
`ifdef MULT_CTRL_DBG_EN
        ,
        .dbg_state      (dst_l),
        .dbg_count      (dcnt_l),
        .dbg_shift_cntr (dsh_l)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sum of the first k nibble partial products, in plain arithmetic.
    function automatic int psum(input int a, input int b, input int k);
        int s;
        s = 0;
        if (k >= 1) s += (a % 16) * (b % 16);
        if (k >= 2) s += (a % 16) * (b / 16) * 16;
        if (k >= 3) s += (a / 16) * (b % 16) * 16;
        if (k >= 4) s += (a / 16) * (b / 16) * 256;
        return s;
    endfunction

    // Model: index 0 = edge-triggered instance, 1 = level-sensitive instance.
    int m_prod[2];
    int m_a[2];
    int m_b[2];
    int m_k[2];
    bit m_done[2];
    bit m_run[2];
    bit m_startq[2];
    bit mdl_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_prod[i]   = 0;
                m_done[i]   = 1'b0;
                m_run[i]    = 1'b0;
                m_k[i]      = 0;
                m_a[i]      = 0;
                m_b[i]      = 0;
                m_startq[i] = 1'b0;
            end else begin
                if (m_run[i]) begin
                    m_k[i]++;
                    m_prod[i] = psum(m_a[i], m_b[i], m_k[i]);
                    if (m_k[i] == 4) begin
                        m_run[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else if (start && (i == 1 || !m_startq[i])) begin
                    m_a[i]    = dataa;
                    m_b[i]    = datab;
                    m_prod[i] = 0;
                    m_k[i]    = 0;
                    m_done[i] = 1'b0;
                    m_run[i]  = 1'b1;
                end
                m_startq[i] = start;
            end
        end
        if (!rst_n) mdl_valid = 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mdl_valid) begin
            check("edge.product", {16'h0, prod_e}, m_prod[0]);
            check("edge.done",    {31'h0, done_e}, {31'h0, m_done[0]});
            check("edge.busy",    {31'h0, busy_e}, {31'h0, m_run[0]});
            check("lvl.product",  {16'h0, prod_l}, m_prod[1]);
            check("lvl.done",     {31'h0, done_l}, {31'h0, m_done[1]});
            check("lvl.busy",     {31'h0, busy_l}, {31'h0, m_run[1]});
            if (m_done[0]) check("edge.full_mul", {16'h0, prod_e}, m_a[0] * m_b[0]);
        end
    end

    task automatic pulse(input logic [7:0] a, input logic [7:0] b);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int exp_steps[4];
    int rises_e, rises_l;
    logic pd_e, pd_l;

    initial begin
        exp_steps[0] = 8;
        exp_steps[1] = 104;
        exp_steps[2] = 168;
        exp_steps[3] = 936;

        rst_n = 1'b0;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle.product", {16'h0, prod_e}, 32'h0);
            check("idle.done",    {31'h0, done_e}, 32'h0);
            check("idle.busy",    {31'h0, busy_e}, 32'h0);
        end

        // 0x12 * 0x34, step-by-step accumulation.
        pulse(8'h12, 8'h34);
        check("t2.busy_e0",    {31'h0, busy_e}, 32'h1);
        check("t2.product_e0", {16'h0, prod_e}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2.step_product", {16'h0, prod_e}, exp_steps[i]);
            check("t2.step_busy",    {31'h0, busy_e}, (i < 3) ? 32'h1 : 32'h0);
            check("t2.step_done",    {31'h0, done_e}, (i == 3) ? 32'h1 : 32'h0);
        end
        repeat (3) @(negedge clk);
        check("t2.held_done",    {31'h0, done_e}, 32'h1);
        check("t2.held_product", {16'h0, prod_e}, 32'h3A8);

        // 0xFF * 0xFF, then 7 * 9.
        pulse(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        check("t3.ff_product", {16'h0, prod_e}, 32'hFE01);
        check("t3.ff_done",    {31'h0, done_e}, 32'h1);
        pulse(8'h07, 8'h09);
        check("t3.done_cleared", {31'h0, done_e}, 32'h0);
        repeat (4) @(negedge clk);
        check("t3.small_product", {16'h0, prod_e}, 32'h3F);
        check("t3.small_done",    {31'h0, done_e}, 32'h1);

        // Start during CALC with changed operands is ignored.
        pulse(8'h12, 8'h34);
        @(negedge clk);
        dataa = 8'hFF;
        datab = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t4.busy_before_end", {31'h0, busy_e}, 32'h1);
        @(negedge clk);
        check("t4.product", {16'h0, prod_e}, 32'h3A8);
        check("t4.done",    {31'h0, done_e}, 32'h1);
        check("t4.lvl_product", {16'h0, prod_l}, 32'h3A8);

        // Reset mid-CALC at count=2.
        pulse(8'h12, 8'h34);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5.product", {16'h0, prod_e}, 32'h0);
        check("t5.busy",    {31'h0, busy_e}, 32'h0);
        check("t5.done",    {31'h0, done_e}, 32'h0);
        pulse(8'h07, 8'h09);
        repeat (4) @(negedge clk);
        check("t5.after_product", {16'h0, prod_e}, 32'h3F);

        // Start held 12 cycles: one run in edge mode, back-to-back in level mode.
        rises_e = 0;
        rises_l = 0;
        pd_e = done_e;
        pd_l = done_l;
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 11) start = 1'b0;
            if (done_e && !pd_e) rises_e++;
            if (done_l && !pd_l) rises_l++;
            pd_e = done_e;
            pd_l = done_l;
        end
        check("t6.edge_runs", rises_e, 32'd1);
        check("t6.lvl_runs",  rises_l, 32'd3);
        check("t6.lvl_product", {16'h0, prod_l}, 32'h3A8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
